// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fixed-latency imem request tracking and a
// small PC-tagged instruction buffer feeding decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] ResetVector   = 32'h0000_0000,
  parameter int          IMemAddrWidth = 12,
  parameter int          MemLatency    = 1,
  parameter int          FifoDepth     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [IMemAddrWidth-1:0] imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic                     align_error
);

  localparam int AW = $clog2(FifoDepth);
  localparam int CW = $clog2(FifoDepth + MemLatency + 1) + 1;

  logic [31:0] pc_reg;
  logic        align_error_reg;
  logic        live_reg    [MemLatency];
  logic [31:0] pipe_pc_reg [MemLatency];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [31:0] fifo_instr_reg [FifoDepth];
  logic [31:0] fifo_pc_reg    [FifoDepth];

  logic [AW:0]   occupancy;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] credits;
  logic          push;
  logic          pop;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MemLatency; i++) begin
      in_flight = in_flight + CW'(live_reg[i]);
    end
  end

  // Every issued fetch reserves a buffer slot until it is popped, so the FIFO can never overflow.
  assign occupancy   = wr_ptr_reg - rd_ptr_reg;
  assign credits     = CW'(occupancy) + in_flight;
  assign imem_req    = !reset && !align_error_reg && !redirect_valid && (credits < CW'(FifoDepth));
  assign imem_addr   = pc_reg[IMemAddrWidth-1:0];
  assign align_error = align_error_reg;

  assign out_valid = (occupancy != '0);
  assign out_instr = fifo_instr_reg[rd_ptr_reg[AW-1:0]];
  assign out_pc    = fifo_pc_reg[rd_ptr_reg[AW-1:0]];

  // A flush wins over a returning response and over a same-cycle pop.
  assign push = live_reg[MemLatency-1] && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  generate
    for (genvar gi = 0; gi < MemLatency; gi++) begin : g_track
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            live_reg[gi]    <= 1'b0;
            pipe_pc_reg[gi] <= '0;
          end else begin
            live_reg[gi]    <= imem_req;
            pipe_pc_reg[gi] <= pc_reg;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (reset) begin
            live_reg[gi]    <= 1'b0;
            pipe_pc_reg[gi] <= '0;
          end else begin
            live_reg[gi]    <= live_reg[gi-1] && !redirect_valid;
            pipe_pc_reg[gi] <= pipe_pc_reg[gi-1];
          end
        end
      end
    end

    for (genvar gi = 0; gi < FifoDepth; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          fifo_instr_reg[gi] <= '0;
          fifo_pc_reg[gi]    <= '0;
        end else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          fifo_instr_reg[gi] <= imem_rdata;
          fifo_pc_reg[gi]    <= pipe_pc_reg[MemLatency-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= ResetVector;
      align_error_reg <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (redirect_valid) begin
      pc_reg          <= redirect_pc;
      align_error_reg <= (redirect_pc[1:0] != 2'b00);
      rd_ptr_reg      <= wr_ptr_reg;
    end else begin
      if (imem_req) pc_reg <= pc_reg + 32'd4;
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (latency 1 and 3) share one stimulus stream and are
// checked every cycle against a queue-level model, plus directed literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RV_A = 32'h0000_0100;
  localparam logic [31:0] RV_B = 32'hFFFF_FFFC;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b1;

  logic        a_req, b_req, a_ov, b_ov, a_ae, b_ae;
  logic [11:0] a_addr;
  logic [31:0] b_addr, a_instr, b_instr, a_pc, b_pc;
  logic [31:0] rdata_w [2];

  logic        req_w   [2];
  logic [31:0] addr_w  [2];
  logic        ov_w    [2];
  logic [31:0] instr_w [2];
  logic [31:0] opc_w   [2];
  logic        ae_w    [2];

  assign req_w[0] = a_req;   assign req_w[1] = b_req;
  assign addr_w[0] = {20'h0, a_addr}; assign addr_w[1] = b_addr;
  assign ov_w[0] = a_ov;     assign ov_w[1] = b_ov;
  assign instr_w[0] = a_instr; assign instr_w[1] = b_instr;
  assign opc_w[0] = a_pc;    assign opc_w[1] = b_pc;
  assign ae_w[0] = a_ae;     assign ae_w[1] = b_ae;

  fetch_unit #(.ResetVector(RV_A), .IMemAddrWidth(12), .MemLatency(1), .FifoDepth(D)) dut_a (
    .clk(clk), .reset(reset), .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(rdata_w[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(a_ov),
    .out_ready(out_ready), .out_instr(a_instr), .out_pc(a_pc), .align_error(a_ae));

  fetch_unit #(.ResetVector(RV_B), .IMemAddrWidth(32), .MemLatency(3), .FifoDepth(D)) dut_b (
    .clk(clk), .reset(reset), .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(rdata_w[1]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(b_ov),
    .out_ready(out_ready), .out_instr(b_instr), .out_pc(b_pc), .align_error(b_ae));

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] rvec(input int d);
    return (d == 0) ? RV_A : RV_B;
  endfunction

  function automatic logic [31:0] amask(input int d, input logic [31:0] a);
    return (d == 0) ? (a & 32'h0000_0FFF) : a;
  endfunction

  // Odd multiplier makes the word a bijection of the address, so every fetch is distinguishable.
  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", name, d, act, exp);
    end
  endtask

  // Queue-level model: buffered {pc} list, in-flight list of {pc, issue cycle}.
  logic [31:0] m_pc   [2];
  bit          m_al   [2];
  logic [31:0] m_fpc  [2][16];
  int          m_fcnt [2];
  logic [31:0] m_ipc  [2][8];
  int          m_it   [2][8];
  int          m_icnt [2];
  bit          started = 1'b0;
  int          cyc = 0;

  bit          h_req  [2][8];
  logic [31:0] h_addr [2][8];
  logic [31:0] dl     [2][8192];
  int          dl_n   [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      dl_n[d] = 0; m_fcnt[d] = 0; m_icnt[d] = 0;
      for (int k = 0; k < 8; k++) h_req[d][k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit exp_req;
      h_req[d][cyc % 8]  = req_w[d];
      h_addr[d][cyc % 8] = addr_w[d];
      exp_req = !reset && !m_al[d] && !redirect_valid && ((m_fcnt[d] + m_icnt[d]) < D);
      if (started) begin
        chk("imem_req", d, req_w[d], exp_req);
        if (exp_req) chk("imem_addr", d, addr_w[d], amask(d, m_pc[d]));
        chk("out_valid", d, ov_w[d], m_fcnt[d] > 0);
        if (m_fcnt[d] > 0) begin
          chk("out_pc", d, opc_w[d], m_fpc[d][0]);
          chk("out_instr", d, instr_w[d], hash(amask(d, m_fpc[d][0])));
        end
        chk("align_error", d, ae_w[d], m_al[d]);
      end
      if (ov_w[d] && out_ready && !reset && !redirect_valid && dl_n[d] < 8192) begin
        dl[d][dl_n[d]] = opc_w[d];
        dl_n[d]++;
      end
      if (reset) begin
        m_pc[d] = rvec(d); m_al[d] = 1'b0; m_fcnt[d] = 0; m_icnt[d] = 0;
      end else if (redirect_valid) begin
        m_pc[d] = redirect_pc; m_al[d] = (redirect_pc[1:0] != 2'b00);
        m_fcnt[d] = 0; m_icnt[d] = 0;
      end else begin
        if (m_fcnt[d] > 0 && out_ready) begin
          for (int k = 0; k < 15; k++) m_fpc[d][k] = m_fpc[d][k+1];
          m_fcnt[d]--;
        end
        if (m_icnt[d] > 0 && m_it[d][0] == cyc - lat(d)) begin
          m_fpc[d][m_fcnt[d]] = m_ipc[d][0];
          m_fcnt[d]++;
          for (int k = 0; k < 7; k++) begin
            m_ipc[d][k] = m_ipc[d][k+1];
            m_it[d][k]  = m_it[d][k+1];
          end
          m_icnt[d]--;
        end
        if (m_fcnt[d] > D) begin
          mismatched++;
          $display("FAIL fifo_overflow dut%0d: occupancy %0d exceeds depth %0d", d, m_fcnt[d], D);
        end
        if (exp_req) begin
          m_ipc[d][m_icnt[d]] = m_pc[d];
          m_it[d][m_icnt[d]]  = cyc;
          m_icnt[d]++;
          m_pc[d] = m_pc[d] + 32'd4;
        end
      end
    end
    if (reset) started = 1'b1;
    cyc++;
  end

  // Synchronous imem: data for a request appears exactly lat cycles later, noise otherwise.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (cyc >= lat(d) && h_req[d][(cyc - lat(d)) % 8])
        rdata_w[d] = hash(h_addr[d][(cyc - lat(d)) % 8]);
      else
        rdata_w[d] = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base [2];
  int cnt  [2];

  initial begin
    logic [31:0] tmp;
    int r;
    rdata_w[0] = 32'h0; rdata_w[1] = 32'h0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, ov_w[d], 1'b0);
      chk("rst_out_pc", d, opc_w[d], 32'h0);
      chk("rst_out_instr", d, instr_w[d], 32'h0);
      chk("rst_align", d, ae_w[d], 1'b0);
      chk("rst_req", d, req_w[d], 1'b0);
    end

    // Reset release with out_ready=1: latency and first addresses.
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      base[d] = dl_n[d];
      chk("first_req", d, req_w[d], 1'b1);
      chk("first_addr", d, addr_w[d], amask(d, rvec(d)));
    end
    for (int k = 0; k < 7; k++) begin
      for (int d = 0; d < 2; d++) chk($sformatf("lat_valid_c%0d", k), d, ov_w[d], k >= lat(d) + 1);
      if (k == 1) chk("second_addr", 0, addr_w[0], 32'h104);
      tick();
    end
    repeat (10) tick();
    chk("throughput", 0, dl_n[0] - base[0], 15);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        chk($sformatf("start_seq%0d", i), d, dl[d][base[d] + i], rvec(d) + 32'(4 * i));

    // Backpressure from an empty buffer.
    reset = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 10; k++) begin
      for (int d = 0; d < 2; d++) cnt[d] += int'(req_w[d]);
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      chk("bp_req_count", d, cnt[d], D);
      chk("bp_req_idle", d, req_w[d], 1'b0);
      chk("bp_valid", d, ov_w[d], 1'b1);
      chk("bp_pc_held", d, opc_w[d], rvec(d));
      chk("bp_instr_held", d, instr_w[d], hash(amask(d, rvec(d))));
      base[d] = dl_n[d];
    end
    out_ready = 1'b1;
    repeat (20) tick();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 6; i++)
        chk($sformatf("bp_seq%0d", i), d, dl[d][base[d] + i], rvec(d) + 32'(4 * i));

    // Redirect to 0x200 with buffered and in-flight fetches.
    out_ready = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("redir_req", d, req_w[d], 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("redir_flush_valid", d, ov_w[d], 1'b0);
      base[d] = dl_n[d];
    end
    repeat (12) tick();
    for (int d = 0; d < 2; d++) begin
      chk("redir_first_pc", d, dl[d][base[d]], 32'h200);
      chk("redir_second_pc", d, dl[d][base[d] + 1], 32'h204);
    end

    // Misaligned redirect halts fetch; an aligned one resumes it.
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    #1;
    cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < 2; d++) begin
        chk("mis_align_error", d, ae_w[d], 1'b1);
        cnt[d] += int'(req_w[d]);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) chk("mis_req_count", d, cnt[d], 0);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("realign_clear", d, ae_w[d], 1'b0);
      base[d] = dl_n[d];
    end
    repeat (12) tick();
    for (int d = 0; d < 2; d++) chk("realign_first_pc", d, dl[d][base[d]], 32'h300);

    // Reset mid-stream while fetches are in flight.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_valid", d, ov_w[d], 1'b0);
      base[d] = dl_n[d];
    end
    repeat (15) tick();
    for (int d = 0; d < 2; d++) chk("midrst_first_pc", d, dl[d][base[d]], rvec(d));

    // Randomized traffic checked cycle by cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 59);
      redirect_valid = (r < 2);
      tmp = $urandom;
      tmp[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      redirect_pc = tmp;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0; redirect_valid = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
